// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: paces enemy shots by game tick and phase, picks a shooter
// round-robin among alive enemies and the lowest free bullet slot.
module enemy_fire_scheduler #(
    parameter int unsigned MAX_ENEMY        = 15,
    parameter int unsigned MAX_ENEMY_BULLET = 31,
    parameter int unsigned INTERVAL_P0      = 24,
    parameter int unsigned INTERVAL_P1      = 16,
    parameter int unsigned INTERVAL_P2      = 12,
    parameter int unsigned INTERVAL_P3      = 8
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Tick,
    input  logic                        i_Enable,
    input  logic [1:0]                  i_Phase,
    input  logic [MAX_ENEMY-1:0]        i_EnemyState,
    input  logic [MAX_ENEMY_BULLET-1:0] i_SlotBusy,
    output logic                        o_Spawn,
    output logic [3:0]                  o_SpawnEnemy,
    output logic [4:0]                  o_SpawnSlot,
    output logic                        o_Pending
);

    localparam int unsigned EW = 4;
    localparam int unsigned SW = 5;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_SEARCH = 2'd2,
        S_GRANT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] rr_last_q, rr_last_d;
    logic          spawn_q, spawn_d;
    logic [EW-1:0] spawn_enemy_q, spawn_enemy_d;
    logic [SW-1:0] spawn_slot_q, spawn_slot_d;
    logic          pending_q, pending_d;

    logic          enemy_found_c;
    logic [EW-1:0] enemy_pick_c;
    logic          slot_found_c;
    logic [SW-1:0] slot_pick_c;
    logic [CW-1:0] reload_c;

    function automatic logic [CW-1:0] interval_for(input logic [1:0] ph);
        case (ph)
            2'd0:    interval_for = CW'(INTERVAL_P0);
            2'd1:    interval_for = CW'(INTERVAL_P1);
            2'd2:    interval_for = CW'(INTERVAL_P2);
            default: interval_for = CW'(INTERVAL_P3);
        endcase
    endfunction

    assign reload_c = interval_for(i_Phase);

    // Round-robin shooter: first alive enemy after the last shooter, wrapping mod MAX_ENEMY.
    always_comb begin
        int unsigned idx;
        idx           = 0;
        enemy_found_c = 1'b0;
        enemy_pick_c  = '0;
        for (int unsigned i = 1; i <= MAX_ENEMY; i++) begin
            idx = (32'(rr_last_q) + i) % MAX_ENEMY;
            if (!enemy_found_c && i_EnemyState[idx]) begin
                enemy_found_c = 1'b1;
                enemy_pick_c  = EW'(idx);
            end
        end
    end

    // Lowest free slot; scanning downward leaves the lowest index as the final pick.
    always_comb begin
        slot_found_c = 1'b0;
        slot_pick_c  = '0;
        for (int unsigned s = MAX_ENEMY_BULLET; s > 0; s--) begin
            if (!i_SlotBusy[s-1]) begin
                slot_found_c = 1'b1;
                slot_pick_c  = SW'(s - 1);
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= CW'(INTERVAL_P0);
            rr_last_q     <= EW'(MAX_ENEMY - 1);
            spawn_q       <= 1'b0;
            spawn_enemy_q <= '0;
            spawn_slot_q  <= '0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_last_q     <= rr_last_d;
            spawn_q       <= spawn_d;
            spawn_enemy_q <= spawn_enemy_d;
            spawn_slot_q  <= spawn_slot_d;
            pending_q     <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_Enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_COUNT;
                S_COUNT:  if (i_Tick && (cnt_q <= CW'(1))) state_d = S_SEARCH;
                S_SEARCH: begin
                    if (!enemy_found_c)    state_d = S_COUNT;
                    else if (slot_found_c) state_d = S_GRANT;
                end
                S_GRANT:  state_d = S_COUNT;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Counter, round-robin pointer and registered outputs.
    always_comb begin
        cnt_d         = cnt_q;
        rr_last_d     = rr_last_q;
        spawn_d       = 1'b0;
        spawn_enemy_d = spawn_enemy_q;
        spawn_slot_d  = spawn_slot_q;
        pending_d     = 1'b0;
        if (state_q == S_GRANT) rr_last_d = spawn_enemy_q;
        if (!i_Enable) begin
            cnt_d = reload_c;
        end else begin
            case (state_q)
                S_IDLE:  cnt_d = reload_c;
                S_COUNT: begin
                    if (i_Tick) cnt_d = (cnt_q <= CW'(1)) ? reload_c : cnt_q - CW'(1);
                end
                S_SEARCH: begin
                    if (enemy_found_c && slot_found_c) begin
                        spawn_d       = 1'b1;
                        spawn_enemy_d = enemy_pick_c;
                        spawn_slot_d  = slot_pick_c;
                    end else if (enemy_found_c) begin
                        pending_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Spawn      = spawn_q;
    assign o_SpawnEnemy = spawn_enemy_q;
    assign o_SpawnSlot  = spawn_slot_q;
    assign o_Pending    = pending_q;

endmodule
